// File: rtl/weight_pattern_gen.sv
// Enumerates every WIDTH-bit word with popcount k in ascending order over a
// valid/ready stream, stepping with Gosper's hack (no divider).
module weight_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IDXW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CW-1:0]     weight,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic [IDXW-1:0]   out_index,
    output logic              done,
    output logic              err
);

    localparam int            SW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] k);
        logic [WIDTH-1:0] m;
        m = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i < int'(k));
        end
        return m;
    endfunction

    // Final pattern for weight k: all k ones packed at the top.
    function automatic logic [WIDTH-1:0] top_ones(input logic [CW-1:0] k);
        logic [WIDTH-1:0] m;
        m = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (i >= (WIDTH - int'(k)));
        end
        return m;
    endfunction

    function automatic logic [SW-1:0] ctz(input logic [WIDTH:0] v);
        logic [SW-1:0] n;
        n = {SW{1'b0}};
        for (int i = WIDTH; i >= 0; i--) begin
            if (v[i]) begin
                n = SW'(i);
            end
        end
        return n;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_k;
    logic [CW-1:0]    w_k_nxt;
    logic [WIDTH-1:0] r_pattern;
    logic [WIDTH-1:0] w_pat_nxt;
    logic [IDXW-1:0]  r_index;
    logic [IDXW-1:0]  w_idx_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_c;
    logic [WIDTH:0]   w_r;
    logic [WIDTH:0]   w_g_wide;
    logic [WIDTH-1:0] w_gosper;

    // Gosper step in WIDTH+1 bits; only registered when the word is not the last.
    always_comb begin
        w_x      = {1'b0, r_pattern};
        w_c      = w_x & (~w_x + (WIDTH+1)'(1));
        w_r      = w_x + w_c;
        w_g_wide = w_r | (((w_r ^ w_x) >> 2'd2) >> ctz(w_c));
        w_gosper = w_g_wide[WIDTH-1:0];
    end

    // Next-state and next-datapath decode.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_pat_nxt   = r_pattern;
        w_idx_nxt   = r_index;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (weight <= C_WIDTH) begin
                        w_state_nxt = ST_EMIT;
                        w_k_nxt     = weight;
                        w_pat_nxt   = low_ones(weight);
                        w_idx_nxt   = {IDXW{1'b0}};
                        w_last_nxt  = (low_ones(weight) == top_ones(weight));
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_pat_nxt  = w_gosper;
                        w_idx_nxt  = r_index + IDXW'(1);
                        w_last_nxt = (w_gosper == top_ones(r_k));
                    end
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k       <= {CW{1'b0}};
            r_pattern <= {WIDTH{1'b0}};
            r_index   <= {IDXW{1'b0}};
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_k       <= w_k_nxt;
            r_pattern <= w_pat_nxt;
            r_index   <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign busy      = (r_state == ST_EMIT);
    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_pattern;
    assign out_last  = r_last;
    assign out_index = r_index;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Self-checking bench for weight_pattern_gen against a popcount-filter reference.
module tb_weight_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int IDXW  = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CW-1:0]    weight;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [IDXW-1:0]  out_index;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    weight_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .weight    (weight),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_index (out_index),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: every WIDTH-bit value with popcount k, in numeric order.
    task automatic build_ref(input int k);
        logic [WIDTH-1:0] v8;
        exp_q.delete();
        for (int v = 0; v < (1 << WIDTH); v++) begin
            v8 = v[WIDTH-1:0];
            if ($countones(v8) == k) exp_q.push_back(v);
        end
    endtask

    task automatic run_stream(input int k, input bit rand_bp, input int stall_idx, input bit spam);
        int               idx;
        int               cycles;
        int               stall_cnt;
        int               n;
        bit               fin;
        bit               rdy;
        bit               have_prev;
        bit               was_stall;
        logic [WIDTH-1:0] prev_acc;
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] cur;
        logic [IDXW-1:0]  held_idx;
        idx = 0; cycles = 0; stall_cnt = 0; fin = 1'b0;
        have_prev = 1'b0; was_stall = 1'b0;
        prev_acc = '0; held = '0; held_idx = '0;
        build_ref(k);
        n = exp_q.size();
        start  = 1'b1;
        weight = CW'(k);
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cycles < 1000) begin
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("err_quiet", {31'd0, err}, 32'd0);
            if (idx < n) begin
                chk("data", {24'd0, out_data}, exp_q[idx]);
                chk("index", {24'd0, out_index}, idx);
                chk("last", {31'd0, out_last}, {31'd0, (idx == n - 1)});
            end
            chk("popcount", $countones(out_data), k);
            if (was_stall) begin
                chk("stall_data", {24'd0, out_data}, {24'd0, held});
                chk("stall_index", {24'd0, out_index}, {24'd0, held_idx});
            end
            if (rand_bp) begin
                if (idx == stall_idx && stall_cnt < 3) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            was_stall = !rdy;
            held      = out_data;
            held_idx  = out_index;
            cur       = out_data;
            if (spam) begin
                start  = 1'($urandom_range(0, 1));
                weight = CW'($urandom_range(0, 9));
            end
            @(negedge clk);
            cycles++;
            if (rdy) begin
                if (have_prev) chk("ascending", {31'd0, (cur > prev_acc)}, 32'd1);
                prev_acc  = cur;
                have_prev = 1'b1;
                if (idx == n - 1) fin = 1'b1;
                idx++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("finished", {31'd0, fin}, 32'd1);
        chk("word_count", idx, n);
        chk("done", {31'd0, done}, 32'd1);
        chk("valid_drop", {31'd0, out_valid}, 32'd0);
        chk("busy_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_pulse_end", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; weight = '0; out_ready = 1'b0;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_index", {24'd0, out_index}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_stream(3, 1'b0, -1, 1'b0);
        run_stream(0, 1'b0, -1, 1'b0);
        run_stream(8, 1'b0, -1, 1'b0);

        // Out-of-range weight.
        start = 1'b1; weight = 4'd9;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_valid", {31'd0, out_valid}, 32'd0);
        chk("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        chk("err_valid2", {31'd0, out_valid}, 32'd0);

        run_stream(4, 1'b1, 5, 1'b0);

        // Start accepted in the cycle done pulses.
        start = 1'b1; weight = 4'd0;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        chk("k0_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("k0_done", {31'd0, done}, 32'd1);
        start = 1'b1; weight = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_data", {24'd0, out_data}, 32'h01);
        repeat (8) @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        out_ready = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-run.
        start = 1'b1; weight = 4'd2; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (out_index != 8'd10 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("reach_idx10", {24'd0, out_index}, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_index", {24'd0, out_index}, 32'd0);
        chk("arst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("arst_no_done", {31'd0, done}, 32'd0);
        chk("arst_idle", {31'd0, out_valid}, 32'd0);

        run_stream(1, 1'b0, -1, 1'b1);

        repeat (6) run_stream($urandom_range(0, 8), 1'b1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
